instruction_fetch_unit: RTL and testbench

//  Producer side of the Instruction_Register load interface. Generates PC, runs a
//  req/ack read handshake with instruction memory and buffers returned words in a

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path types and constants
package cpu_pkg;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {IDLE, REQ, FLUSH, FAULT} fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer of {pc,instr} entries with flush
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == '0);
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        head_data = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC generation, imem req/ack handshake and IR load
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        ir_stall,
    output logic        ir_write,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        fetch_fault
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_ack;
    logic          full;
    logic          empty;
    logic          push;
    logic          space_after_ack;
    logic          aligned;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    always_comb begin
        ir_write        = !empty && !ir_stall && !redirect_valid;
        push            = (state == REQ) && imem_ack && !redirect_valid;
        push_data.pc    = pc;
        push_data.instr = imem_rdata;
        // The acked word is no longer outstanding but now occupies a slot.
        count_after_ack = count + CW'(1) - CW'(ir_write);
        space_after_ack = count_after_ack < CW'(DEPTH);
        aligned         = (redirect_pc[1:0] == 2'b00);
        instruction_out = head.instr;
        pc_out          = head.pc;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (ir_write),
        .flush     (redirect_valid),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            // An un-acked request is never withdrawn; its data is dropped later.
            if (imem_ack) imem_req <= 1'b0;
            if (!aligned) begin
                fetch_fault <= 1'b1;
                state       <= FAULT;
            end else begin
                fetch_fault <= 1'b0;
                pc          <= redirect_pc;
                state       <= (imem_req && !imem_ack) ? FLUSH : IDLE;
            end
        end else begin
            case (state)
                IDLE: if (fetch_en && !full) begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state     <= REQ;
                end
                REQ: if (imem_ack) begin
                    pc <= pc + PC_STEP;
                    if (fetch_en && space_after_ack) begin
                        imem_addr <= pc + PC_STEP;
                    end else begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                FLUSH: if (imem_ack) begin
                    if (fetch_en) begin
                        imem_addr <= pc;
                        state     <= REQ;
                    end else begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                FAULT: if (imem_req && imem_ack) imem_req <= 1'b0;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_stall;
    logic        ir_write;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        fetch_fault;

    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] req_log[$];
    int          fixed_wait = 0;
    int          cur_wait = 0;
    bit          rand_wait = 1'b0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .ir_stall        (ir_stall),
        .ir_write        (ir_write),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .fetch_fault     (fetch_fault)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    // Instruction memory: acks after cur_wait idle cycles, logs every completed address.
    initial begin : responder
        int          waitc;
        logic [31:0] held;
        waitc = 0;
        held = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (reset_n && imem_req) begin
                if (waitc == 0) held = imem_addr;
                else begin
                    total++;
                    if (imem_addr !== held) begin
                        bad++;
                        $display("FAIL addr_stable got=%h want=%h", imem_addr, held);
                    end
                end
                if (waitc >= cur_wait) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    req_log.push_back(imem_addr);
                    waitc = 0;
                    cur_wait = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
                end else waitc++;
            end else waitc = 0;
        end
    end

    // Reference: IR loads form a consecutive PC stream from the last reset/redirect target.
    initial begin : ir_monitor
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && ir_write) begin
                total++;
                if (pc_out !== exp_pc || instruction_out !== mem_word(exp_pc) ||
                    ir_stall || redirect_valid) begin
                    bad++;
                    $display("FAIL ir_load pc=%h instr=%h want pc=%h instr=%h stall=%b redir=%b",
                             pc_out, instruction_out, exp_pc, mem_word(exp_pc), ir_stall, redirect_valid);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
    end

    task automatic wait_idle();
        int quiet = 0;
        fetch_en = 1'b0;
        ir_stall = 1'b0;
        for (int i = 0; i < 100 && quiet < 3; i++) begin
            @(negedge clk);
            #1;
            quiet = (!imem_req && !ir_write) ? quiet + 1 : 0;
        end
        total++;
        if (quiet < 3) begin
            bad++;
            $display("FAIL idle_timeout req=%b ir_write=%b want quiet", imem_req, ir_write);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        ir_stall = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, ir_write, instruction_out, pc_out, fetch_fault} !== '0) begin
            bad++;
            $display("FAIL reset req=%b addr=%h irw=%b instr=%h pc=%h fault=%b want all 0",
                     imem_req, imem_addr, ir_write, instruction_out, pc_out, fetch_fault);
        end
    endtask

    task automatic test_sequential();
        fixed_wait = 0;
        cur_wait = 0;
        rand_wait = 1'b0;
        exp_pc = 32'h0;
        req_log.delete();
        fetch_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10 && !imem_ack; i++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        total++;
        if (ir_write !== 1'b1 || pc_out !== 32'h0) begin
            bad++;
            $display("FAIL first_load_latency irw=%b pc=%h want 1/00000000", ir_write, pc_out);
        end
        for (int i = 0; i < 50 && req_log.size() < 8; i++) @(negedge clk);
        total++;
        if (req_log.size() < 8) begin
            bad++;
            $display("FAIL seq_timeout acks=%0d want 8", req_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] want;
                want = 32'(i * 4);
                total++;
                if (req_log[i] !== want) begin
                    bad++;
                    $display("FAIL seq_addr[%0d] got=%h want=%h", i, req_log[i], want);
                end
            end
        end
    endtask

    task automatic test_stall();
        int d0;
        wait_idle();
        cur_wait = 0;
        req_log.delete();
        ir_stall = 1'b1;
        fetch_en = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (req_log.size() != DEPTH || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_fill acks=%0d req=%b want %0d/0", req_log.size(), imem_req, DEPTH);
        end
        d0 = delivered;
        fetch_en = 1'b0;
        ir_stall = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        total++;
        if (delivered - d0 != DEPTH) begin
            bad++;
            $display("FAIL stall_drain got=%0d want=%0d", delivered - d0, DEPTH);
        end
    endtask

    task automatic test_random_traffic();
        int d0;
        wait_idle();
        req_log.delete();
        d0 = delivered;
        rand_wait = 1'b1;
        cur_wait = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            ir_stall = ($urandom_range(0, 3) == 0);
            fetch_en = ($urandom_range(0, 7) != 0);
        end
        wait_idle();
        rand_wait = 1'b0;
        total++;
        if (req_log.size() != delivered - d0 || req_log.size() == 0) begin
            bad++;
            $display("FAIL random_conservation acks=%0d loads=%0d want equal nonzero",
                     req_log.size(), delivered - d0);
        end
    endtask

    task automatic test_redirect_flush();
        logic [31:0] a;
        wait_idle();
        fixed_wait = 3;
        cur_wait = 3;
        fetch_en = 1'b1;
        for (int i = 0; i < 10 && !imem_req; i++) begin
            @(negedge clk);
            #1;
        end
        a = imem_addr;
        req_log.delete();
        redirect_pc = 32'h100;
        redirect_valid = 1'b1;
        exp_pc = 32'h100;
        fixed_wait = 0;
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                bad++;
                $display("FAIL flush_hold req=%b addr=%h want 1/%h", imem_req, imem_addr, a);
            end
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 20 && req_log.size() < 2; i++) @(negedge clk);
        total++;
        if (req_log.size() < 2 || req_log[0] !== a || req_log[1] !== 32'h100) begin
            bad++;
            $display("FAIL flush_next_addr n=%0d first=%h second=%h want %h/00000100",
                     req_log.size(), req_log.size() > 0 ? req_log[0] : 32'hx,
                     req_log.size() > 1 ? req_log[1] : 32'hx, a);
        end
    endtask

    task automatic test_redirect_on_ack();
        wait_idle();
        cur_wait = 0;
        fixed_wait = 0;
        req_log.delete();
        ir_stall = 1'b1;
        fetch_en = 1'b1;
        for (int i = 0; i < 20 && !(imem_ack && req_log.size() == 2); i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (!(imem_ack && req_log.size() == 2) || pc_out !== req_log[0]) begin
            bad++;
            $display("FAIL ack_setup ack=%b acks=%0d head=%h want 1/2/first", imem_ack, req_log.size(), pc_out);
        end
        redirect_pc = 32'h300;
        redirect_valid = 1'b1;
        ir_stall = 1'b0;
        exp_pc = 32'h300;
        #1;
        total++;
        if (ir_write !== 1'b0) begin
            bad++;
            $display("FAIL redirect_blocks_write irw=%b want 0", ir_write);
        end
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        total++;
        if (pc_out !== 32'h0 || instruction_out !== 32'h0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL flushed_empty pc=%h instr=%h req=%b want 0/0/0", pc_out, instruction_out, imem_req);
        end
        @(negedge clk);
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            bad++;
            $display("FAIL redirect_latency req=%b addr=%h want 1/00000300", imem_req, imem_addr);
        end
    endtask

    task automatic test_fault();
        int d0;
        wait_idle();
        d0 = delivered;
        fetch_en = 1'b1;
        redirect_pc = 32'h102;
        redirect_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            redirect_valid = 1'b0;
            total++;
            if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL fault_hold fault=%b req=%b want 1/0", fetch_fault, imem_req);
            end
        end
        req_log.delete();
        redirect_pc = 32'h200;
        redirect_valid = 1'b1;
        exp_pc = 32'h200;
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        total++;
        if (fetch_fault !== 1'b0 || delivered != d0) begin
            bad++;
            $display("FAIL fault_clear fault=%b loads=%0d want 0/0", fetch_fault, delivered - d0);
        end
        for (int i = 0; i < 20 && delivered == d0; i++) @(negedge clk);
        total++;
        if (req_log.size() == 0 || req_log[0] !== 32'h200 || delivered == d0) begin
            bad++;
            $display("FAIL fault_resume acks=%0d loads=%0d want first ack 00000200 and a load",
                     req_log.size(), delivered - d0);
        end
    endtask

    task automatic test_wrap_and_reset();
        wait_idle();
        cur_wait = 0;
        fixed_wait = 0;
        req_log.delete();
        fetch_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        redirect_valid = 1'b1;
        exp_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && req_log.size() < 2; i++) @(negedge clk);
        total++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            bad++;
            $display("FAIL pc_wrap n=%0d want FFFFFFFC then 00000000", req_log.size());
        end
        fixed_wait = 4;
        for (int i = 0; i < 20 && !(imem_req && !imem_ack && cur_wait == 4); i++) begin
            @(negedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, ir_write, instruction_out, pc_out, fetch_fault} !== '0) begin
            bad++;
            $display("FAIL async_reset req=%b addr=%h irw=%b instr=%h pc=%h fault=%b want all 0",
                     imem_req, imem_addr, ir_write, instruction_out, pc_out, fetch_fault);
        end
        fetch_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_random_traffic();
        test_redirect_flush();
        test_redirect_on_ack();
        test_fault();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
